// File: rtl/exc_pipe_chain.sv
// Exception-tracking pipeline chain: carries {valid, pc, bd, exc, code} through
// DEPTH stages with per-stage hold, bubble insertion, flush and a saturating
// count of delivered excepting instructions.
module exc_pipe_chain #(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CODE_W = 5,
   parameter int unsigned PC_W   = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [PC_W-1:0]             in_pc,
   input  logic                        in_bd,
   input  logic                        in_exc,
   input  logic [CODE_W-1:0]           in_code,
   input  logic [DEPTH-2:0]            stage_exc,
   input  logic [(DEPTH-1)*CODE_W-1:0] stage_code,
   input  logic [DEPTH-1:0]            stall_mask,
   input  logic                        flush,
   output logic [DEPTH-1:0]            stage_valid,
   output logic                        out_valid,
   output logic [PC_W-1:0]             out_pc,
   output logic                        out_bd,
   output logic                        out_exc,
   output logic [CODE_W-1:0]           out_code,
   output logic                        any_exc,
   output logic [15:0]                 exc_count
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned LAST  = DEPTH - 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  exc_q, exc_d;
   logic [DEPTH-1:0]  bd_q, bd_d;
   logic [PC_W-1:0]   pc_q [DEPTH];
   logic [PC_W-1:0]   pc_d [DEPTH];
   logic [CODE_W-1:0] code_q [DEPTH];
   logic [CODE_W-1:0] code_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DEPTH-1:0]  hold;
   logic              deliver;

   // A stage holds when it or any downstream stage requests a stall.
   always_comb begin
      hold = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hold[i] = |(stall_mask >> i);
      end
   end

   // Next-state for all stages: reset, then flush, then hold/bubble/transfer.
   always_comb begin
      valid_d = valid_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
      pc_d    = pc_q;
      code_d  = code_q;
      if (reset) begin
         valid_d = '0;
         exc_d   = '0;
         bd_d    = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_d[i]   = '0;
            code_d[i] = '0;
         end
      end else if (flush) begin
         valid_d = '0;
         exc_d   = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            code_d[i] = '0;
         end
      end else begin
         if (!hold[0]) begin
            valid_d[0] = in_valid;
            pc_d[0]    = in_pc;
            bd_d[0]    = in_bd;
            exc_d[0]   = in_exc & in_valid;
            code_d[0]  = in_exc ? in_code : '0;
         end
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (!hold[i+1]) begin
               if (hold[i]) begin
                  valid_d[i+1] = 1'b0;
                  exc_d[i+1]   = 1'b0;
                  code_d[i+1]  = '0;
               end else begin
                  valid_d[i+1] = valid_q[i];
                  pc_d[i+1]    = pc_q[i];
                  bd_d[i+1]    = bd_q[i];
                  exc_d[i+1]   = exc_q[i] | (valid_q[i] & stage_exc[i]);
                  if (exc_q[i]) begin
                     code_d[i+1] = code_q[i];
                  end else if (valid_q[i] && stage_exc[i]) begin
                     code_d[i+1] = stage_code[i*int'(CODE_W) +: CODE_W];
                  end else begin
                     code_d[i+1] = '0;
                  end
               end
            end
         end
      end
   end

   // Saturating count of excepting instructions leaving the last stage.
   always_comb begin
      deliver = valid_q[LAST] & ~stall_mask[LAST];
      cnt_d   = cnt_q;
      if (reset) begin
         cnt_d = '0;
      end else if (deliver && exc_q[LAST] && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
   end

   assign stage_valid = valid_q;
   assign out_valid   = valid_q[LAST];
   assign out_pc      = pc_q[LAST];
   assign out_bd      = bd_q[LAST];
   assign out_exc     = exc_q[LAST];
   assign out_code    = code_q[LAST];
   assign any_exc     = |(valid_q & exc_q);
   assign exc_count   = cnt_q;

endmodule

// File: tb/tb_exc_pipe_chain.sv
// Directed bench for exc_pipe_chain at DEPTH=3.
module tb_exc_pipe_chain;

   localparam int unsigned DEPTH  = 3;
   localparam int unsigned CODE_W = 5;
   localparam int unsigned PC_W   = 32;

   logic                        clk;
   logic                        reset;
   logic                        in_valid;
   logic [PC_W-1:0]             in_pc;
   logic                        in_bd;
   logic                        in_exc;
   logic [CODE_W-1:0]           in_code;
   logic [DEPTH-2:0]            stage_exc;
   logic [(DEPTH-1)*CODE_W-1:0] stage_code;
   logic [DEPTH-1:0]            stall_mask;
   logic                        flush;
   logic [DEPTH-1:0]            stage_valid;
   logic                        out_valid;
   logic [PC_W-1:0]             out_pc;
   logic                        out_bd;
   logic                        out_exc;
   logic [CODE_W-1:0]           out_code;
   logic                        any_exc;
   logic [15:0]                 exc_count;

   int total;
   int bad;
   int ec;

   exc_pipe_chain #(.DEPTH(DEPTH), .CODE_W(CODE_W), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
      .in_exc(in_exc), .in_code(in_code), .stage_exc(stage_exc), .stage_code(stage_code),
      .stall_mask(stall_mask), .flush(flush), .stage_valid(stage_valid),
      .out_valid(out_valid), .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
      .out_code(out_code), .any_exc(any_exc), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_pc      = '0;
      in_bd      = 1'b0;
      in_exc     = 1'b0;
      in_code    = '0;
      stage_exc  = '0;
      stage_code = '0;
      stall_mask = '0;
      flush      = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      in_valid = 1'b1; in_pc = 32'h1234; in_bd = 1'b1; in_exc = 1'b1; in_code = 5'd3;
      reset = 1'b1;
      step(); step(); step();
      total++; if (stage_valid !== 3'b000) begin bad++; $display("FAIL reset_stage_valid got=%b exp=000", stage_valid); end
      total++; if ({out_valid, out_exc, out_bd} !== 3'b000) begin bad++; $display("FAIL reset_out_flags got=%b exp=000", {out_valid, out_exc, out_bd}); end
      total++; if (out_pc !== 32'h0 || out_code !== 5'd0) begin bad++; $display("FAIL reset_out_pc_code got=%h/%h exp=0/0", out_pc, out_code); end
      total++; if (any_exc !== 1'b0 || exc_count !== 16'h0) begin bad++; $display("FAIL reset_exc got=%b/%h exp=0/0", any_exc, exc_count); end
      reset = 1'b0;
      idle_inputs();
      step();
   endtask

   task automatic test_latency();
      in_valid = 1'b1; in_pc = 32'h3000;
      step();
      idle_inputs();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", out_valid); end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin bad++; $display("FAIL latency_out got=%b/%h exp=1/3000", out_valid, out_pc); end
      total++; if (out_exc !== 1'b0 || exc_count !== 16'(ec)) begin bad++; $display("FAIL latency_exc got=%b/%h exp=0/%h", out_exc, exc_count, ec); end
      step();
      total++; if (out_valid !== 1'b0 || exc_count !== 16'(ec)) begin bad++; $display("FAIL latency_drain got=%b/%h exp=0/%h", out_valid, exc_count, ec); end
   endtask

   task automatic test_oldest_wins();
      in_valid = 1'b1; in_pc = 32'h100; in_exc = 1'b1; in_code = 5'd4;
      step();
      idle_inputs();
      total++; if (any_exc !== 1'b1) begin bad++; $display("FAIL oldest_any_exc got=%b exp=1", any_exc); end
      step();
      stage_exc = 2'b10; stage_code = {5'd12, 5'd0};
      step();
      idle_inputs();
      total++; if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_code !== 5'd4) begin bad++; $display("FAIL oldest_out got=%b/%b/%0d exp=1/1/4", out_valid, out_exc, out_code); end
      step();
      ec++;
      total++; if (exc_count !== 16'(ec)) begin bad++; $display("FAIL oldest_count got=%0d exp=%0d", exc_count, ec); end
   endtask

   task automatic test_stage_exc();
      stage_exc = 2'b11; stage_code = {5'd7, 5'd9};
      step(); step();
      idle_inputs();
      total++; if (any_exc !== 1'b0 || stage_valid !== 3'b000) begin bad++; $display("FAIL ignore_invalid got=%b/%b exp=0/000", any_exc, stage_valid); end
      in_valid = 1'b1; in_pc = 32'h200;
      step();
      idle_inputs();
      stage_exc = 2'b01; stage_code = {5'd0, 5'd10};
      step();
      idle_inputs();
      step();
      total++; if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_code !== 5'd10 || out_pc !== 32'h200) begin bad++; $display("FAIL stage_exc_out got=%b/%b/%0d/%h exp=1/1/10/200", out_valid, out_exc, out_code, out_pc); end
      step();
      ec++;
      total++; if (exc_count !== 16'(ec)) begin bad++; $display("FAIL stage_exc_count got=%0d exp=%0d", exc_count, ec); end
   endtask

   task automatic test_stall();
      in_valid = 1'b1; in_pc = 32'hA; step();
      in_pc = 32'hB; in_bd = 1'b1; step();
      in_pc = 32'hC; in_bd = 1'b0; step();
      idle_inputs();
      total++; if (out_pc !== 32'hA || stage_valid !== 3'b111) begin bad++; $display("FAIL stall_fill got=%h/%b exp=a/111", out_pc, stage_valid); end
      stall_mask = 3'b010;
      step();
      total++; if (out_valid !== 1'b0 || stage_valid !== 3'b011) begin bad++; $display("FAIL stall_bubble1 got=%b/%b exp=0/011", out_valid, stage_valid); end
      step();
      total++; if (out_valid !== 1'b0 || stage_valid !== 3'b011) begin bad++; $display("FAIL stall_bubble2 got=%b/%b exp=0/011", out_valid, stage_valid); end
      stall_mask = 3'b000;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'hB || out_bd !== 1'b1) begin bad++; $display("FAIL stall_out_b got=%b/%h/%b exp=1/b/1", out_valid, out_pc, out_bd); end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_bd !== 1'b0) begin bad++; $display("FAIL stall_out_c got=%b/%h/%b exp=1/c/0", out_valid, out_pc, out_bd); end
      step();
      total++; if (out_valid !== 1'b0 || stage_valid !== 3'b000) begin bad++; $display("FAIL stall_drain got=%b/%b exp=0/000", out_valid, stage_valid); end
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_exc = 1'b1; in_code = 5'd2;
      in_pc = 32'h10; step(); in_pc = 32'h14; step(); in_pc = 32'h18; step();
      stall_mask = 3'b111; flush = 1'b1;
      step();
      idle_inputs();
      total++; if (stage_valid !== 3'b000 || any_exc !== 1'b0) begin bad++; $display("FAIL flush_stalled got=%b/%b exp=000/0", stage_valid, any_exc); end
      total++; if (exc_count !== 16'(ec) || out_code !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d/%0d exp=%0d/0", exc_count, out_code, ec); end
      in_valid = 1'b1; in_exc = 1'b1; in_code = 5'd6;
      in_pc = 32'h20; step(); in_pc = 32'h24; step(); in_pc = 32'h28; step();
      flush = 1'b1;
      step();
      idle_inputs();
      ec++;
      total++; if (stage_valid !== 3'b000 || exc_count !== 16'(ec)) begin bad++; $display("FAIL flush_deliver got=%b/%0d exp=000/%0d", stage_valid, exc_count, ec); end
   endtask

   task automatic test_saturation();
      int n;
      n = 16'hFFFE - ec;
      in_valid = 1'b1; in_exc = 1'b1; in_code = 5'd1;
      for (int i = 0; i < n; i++) step();
      idle_inputs();
      for (int i = 0; i < int'(DEPTH) + 1; i++) step();
      total++; if (exc_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", exc_count); end
      in_valid = 1'b1; in_exc = 1'b1;
      for (int i = 0; i < 3; i++) step();
      idle_inputs();
      for (int i = 0; i < int'(DEPTH) + 1; i++) step();
      total++; if (exc_count !== 16'hFFFF) begin bad++; $display("FAIL sat_top got=%h exp=ffff", exc_count); end
      in_valid = 1'b1; in_exc = 1'b1; step();
      idle_inputs();
      for (int i = 0; i < int'(DEPTH) + 1; i++) step();
      total++; if (exc_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", exc_count); end
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; in_exc = 1'b1; in_code = 5'd9; in_bd = 1'b1;
      in_pc = 32'h50; step(); in_pc = 32'h54; step(); in_pc = 32'h58; step();
      stall_mask = 3'b111; in_pc = 32'hDEAD;
      step();
      total++; if (stage_valid !== 3'b111 || any_exc !== 1'b1) begin bad++; $display("FAIL full_stalled got=%b/%b exp=111/1", stage_valid, any_exc); end
      reset = 1'b1; flush = 1'b1;
      step();
      total++; if (stage_valid !== 3'b000 || any_exc !== 1'b0 || exc_count !== 16'h0) begin bad++; $display("FAIL midreset_state got=%b/%b/%h exp=000/0/0", stage_valid, any_exc, exc_count); end
      total++; if (out_pc !== 32'h0 || out_bd !== 1'b0 || out_code !== 5'd0 || out_exc !== 1'b0) begin bad++; $display("FAIL midreset_out got=%h/%b/%0d/%b exp=0/0/0/0", out_pc, out_bd, out_code, out_exc); end
      reset = 1'b0;
      idle_inputs();
      in_valid = 1'b1; in_pc = 32'h4000;
      step();
      idle_inputs();
      total++; if (stage_valid !== 3'b001) begin bad++; $display("FAIL after_reset_entry got=%b exp=001", stage_valid); end
      step(); step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h4000 || out_exc !== 1'b0) begin bad++; $display("FAIL after_reset_out got=%b/%h/%b exp=1/4000/0", out_valid, out_pc, out_exc); end
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      total = 0;
      bad   = 0;
      ec    = 0;
      idle_inputs();
      test_reset();
      test_latency();
      test_oldest_wins();
      test_stage_exc();
      test_stall();
      test_flush();
      test_saturation();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exc_pipe_chain.md
EXC_PIPE_CHAIN -- requirements
Module: exc_pipe_chain

Interface
REQ-001 The module SHALL have parameter DEPTH, default 3, meaning the number of pipeline stages (legal 2..8).
REQ-002 The module SHALL have parameter CODE_W, default 5, meaning the exception-code width.
REQ-003 The module SHALL have parameter PC_W, default 32, meaning the tagged-PC width.
REQ-004 The module SHALL have port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 The module SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 The module SHALL have port in_valid  in  1  meaning an instruction enters stage 0.
REQ-007 The module SHALL have port in_pc  in  PC_W  meaning the PC of the entering instruction.
REQ-008 The module SHALL have port in_bd  in  1  meaning the entering instruction is in a delay slot.
REQ-009 The module SHALL have port in_exc / in_code  in  1 / CODE_W  meaning an exception detected before stage 0.
REQ-010 The module SHALL have port stage_exc  in  DEPTH-1  meaning bit i is an exception raised by the datapath for the current content of stage i.
REQ-011 The module SHALL have port stage_code  in  (DEPTH-1)*CODE_W  meaning slice i is the code for stage_exc[i].
REQ-012 The module SHALL have port stall_mask  in  DEPTH  meaning bit i requests stage i to hold.
REQ-013 The module SHALL have port flush  in  1  meaning all stages are discarded.
REQ-014 The module SHALL have port stage_valid  out  DEPTH  meaning the registered valid bit of each stage.
REQ-015 The module SHALL have ports out_valid, out_pc, out_bd, out_exc, out_code  out  1/PC_W/1/1/CODE_W  meaning the registered contents of stage DEPTH-1.
REQ-016 The module SHALL have port any_exc  out  1  meaning, combinationally, that some valid stage holds exc=1.
REQ-017 The module SHALL have port exc_count  out  16  meaning the saturating count of delivered excepting instructions.

Function
REQ-018 Each stage SHALL hold the fields {valid, pc, bd, exc, code}.
REQ-019 Stage i SHALL be held when any stall_mask[j] with j>=i is 1, so back-pressure propagates upstream.
REQ-020 A held stage SHALL keep all of its fields unchanged.
REQ-021 When stage i is held and stage i+1 is not held, stage i+1 SHALL load a bubble: valid=0, exc=0, code=0, and pc/bd don't-care.
REQ-022 When stage 0 is not held, it SHALL load {in_valid, in_pc, in_bd, in_exc&in_valid, in_exc ? in_code : 0}.
REQ-023 When stage i+1 is not held, it SHALL load stage i with exc' = exc | (valid & stage_exc[i]).
REQ-024 On that transfer, code' SHALL be the existing code if exc=1, otherwise stage_code[i] if stage_exc[i]=1 and valid=1, otherwise 0; the oldest-detected exception always wins.
REQ-025 stage_exc[i] SHALL be ignored while stage i is invalid or held.
REQ-026 Latency from in_valid to out_valid SHALL be exactly DEPTH cycles when no stalls occur.
REQ-027 An instruction SHALL be delivered on a cycle where out_valid=1 and stall_mask[DEPTH-1]=0.
REQ-028 When the delivered instruction has out_exc=1, exc_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-029 flush=1 SHALL clear the valid, exc and code fields of every stage on the next edge, overriding stall_mask and the inputs.
REQ-030 flush SHALL NOT clear exc_count.
REQ-031 A delivery on the same cycle as flush SHALL still be counted.
REQ-032 pc and bd MAY retain their old values under flush.
REQ-033 any_exc SHALL be the OR over all stages of (valid & exc).
REQ-034 any_exc SHALL be purely combinational from registered state.

Reset
REQ-035 reset=1 SHALL, on the next edge, set every stage's valid, exc and code to 0, pc to 0 and bd to 0, and set exc_count to 0.
REQ-036 reset SHALL override flush, stall_mask and all other inputs.
REQ-037 After reset, stage_valid, out_valid, out_exc, out_code, out_pc, out_bd, any_exc and exc_count SHALL all read 0.
REQ-038 Deasserting reset in mid-stream SHALL cause only instructions presented after deassertion to enter the chain.

Verification
REQ-039 Scenario: with DEPTH=3, inject in_valid=1, in_pc=0x3000 at cycle 0 with no stalls -> out_valid=1 and out_pc=0x3000 at cycle 3, out_exc=0, exc_count=0.
REQ-040 Scenario: inject in_exc=1, in_code=4, then stage_exc[1]=1 with code 12 when the instruction is in stage 1 -> out_code=4, out_exc=1, and exc_count=1 after delivery.
REQ-041 Scenario: an instruction without an exception receives stage_exc[0]=1 with code 10 -> it is delivered with out_code=10.
REQ-042 Scenario: hold stall_mask=3'b010 for 2 cycles with instructions A,B,C in flight -> stages 0-1 freeze, stage 2 receives bubbles (out_valid=0 for 2 cycles), and A,B,C later deliver in order with none lost or duplicated.
REQ-043 Scenario: assert flush together with stall_mask=3'b111 while 3 valid instructions are in flight -> stage_valid=0 and any_exc=0 next cycle, and exc_count is unchanged.
REQ-044 Scenario: preload exc_count=0xFFFE by delivering 0xFFFE excepting instructions (or by a forced bench shortcut), then deliver 3 more -> exc_count=0xFFFF and holds.
REQ-045 Scenario: assert reset while the chain is full and stalled -> all outputs read 0 next cycle.
